// File: rtl/cv32e40p_tmr_fault_monitor.sv
// cv32e40p_tmr_fault_monitor
//
// Majority voter and replica diagnosis for the three redundant ALUs of the
// TMR EX stage. The bitwise-majority result is registered into a one-entry
// valid/ready output stage. Each replica is tracked by a small state machine
// that condemns it after THRESH consecutive mismatching transfers.
//
// state   | meaning
// --------+-------------------------------------------------------------
// HEALTHY | replica agreed with the vote on its last accepted transfer
// SUSPECT | replica has mismatched on 1..THRESH-1 consecutive transfers
// FAULTY  | replica reached THRESH consecutive mismatches (sticky)
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   valid_i / ready_o    upstream handshake; res1_i..res3_i are replica results
//   valid_o / ready_i    downstream handshake; result_o is the voted result
//   mismatch_o           per-replica mismatch flags for the held result
//   err_clr_i            clears all diagnosis state
//   fault_o              replica k is FAULTY
//   uncorrectable_o      sticky: some transfer had all replicas pairwise different
//   err_cnt_o            saturating count of accepted transfers with any mismatch

module cv32e40p_tmr_fault_monitor #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [2:0]       mismatch_o,
  input  logic             err_clr_i,
  output logic [2:0]       fault_o,
  output logic             uncorrectable_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULTY  = 2'd2
  } rep_state_e;

  localparam logic [3:0] THRESH_L = 4'(THRESH);

  logic [WIDTH-1:0] maj;
  logic [2:0]       mm;
  logic             triple;
  logic             accept;

  rep_state_e state_q  [3];
  logic [3:0] streak_q [3];

  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;

  assign maj    = (res1_i & res2_i) | (res2_i & res3_i) | (res1_i & res3_i);
  assign mm[0]  = (res1_i != maj);
  assign mm[1]  = (res2_i != maj);
  assign mm[2]  = (res3_i != maj);
  assign triple = (res1_i != res2_i) && (res2_i != res3_i) && (res1_i != res3_i);

  // Output stage: a new accept overwrites the slot (covers simultaneous
  // handoff); a handoff with nothing new behind it empties the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      result_o   <= '0;
      mismatch_o <= '0;
    end else if (accept) begin
      valid_o    <= 1'b1;
      result_o   <= maj;
      mismatch_o <= mm;
    end else if (ready_i) begin
      valid_o    <= 1'b0;
    end
  end

  // Diagnosis: clear wins over a same-cycle accept, so that transfer is
  // never counted against the replicas.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr_i) begin
      fault_o         <= '0;
      uncorrectable_o <= 1'b0;
      err_cnt_o       <= '0;
      for (int k = 0; k < 3; k++) begin
        state_q[k]  <= HEALTHY;
        streak_q[k] <= '0;
      end
    end else if (accept) begin
      if (|mm && (err_cnt_o != {CNT_W{1'b1}})) begin
        err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
      if (triple) begin
        uncorrectable_o <= 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        case (state_q[k])
          HEALTHY: begin
            if (mm[k]) begin
              streak_q[k] <= 4'd1;
              if (THRESH_L == 4'd1) begin
                state_q[k] <= FAULTY;
                fault_o[k] <= 1'b1;
              end else begin
                state_q[k] <= SUSPECT;
              end
            end
          end
          SUSPECT: begin
            if (mm[k]) begin
              streak_q[k] <= streak_q[k] + 4'd1;
              if ((streak_q[k] + 4'd1) == THRESH_L) begin
                state_q[k] <= FAULTY;
                fault_o[k] <= 1'b1;
              end
            end else begin
              state_q[k]  <= HEALTHY;
              streak_q[k] <= '0;
            end
          end
          FAULTY: begin
          end
          default: begin
            state_q[k]  <= HEALTHY;
            streak_q[k] <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_tmr_fault_monitor.sv
// Directed bench for cv32e40p_tmr_fault_monitor. A second instance with
// CNT_W=2 shares the stimulus so counter saturation can be observed.

module tb_cv32e40p_tmr_fault_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] res1_i, res2_i, res3_i;
  logic        ready_i;
  logic        err_clr_i;

  logic        ready_o, valid_o, uncorrectable_o;
  logic [31:0] result_o;
  logic [2:0]  mismatch_o, fault_o;
  logic [7:0]  err_cnt_o;

  logic        ready_o2, valid_o2, uncorrectable_o2;
  logic [31:0] result_o2;
  logic [2:0]  mismatch_o2, fault_o2;
  logic [1:0]  err_cnt_o2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cv32e40p_tmr_fault_monitor #(.WIDTH(32), .THRESH(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .res1_i(res1_i), .res2_i(res2_i), .res3_i(res3_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .mismatch_o(mismatch_o), .err_clr_i(err_clr_i), .fault_o(fault_o),
    .uncorrectable_o(uncorrectable_o), .err_cnt_o(err_cnt_o)
  );

  cv32e40p_tmr_fault_monitor #(.WIDTH(32), .THRESH(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o2),
    .res1_i(res1_i), .res2_i(res2_i), .res3_i(res3_i),
    .valid_o(valid_o2), .ready_i(ready_i), .result_o(result_o2),
    .mismatch_o(mismatch_o2), .err_clr_i(err_clr_i), .fault_o(fault_o2),
    .uncorrectable_o(uncorrectable_o2), .err_cnt_o(err_cnt_o2)
  );

  // One accepted transfer (ready_i=1 keeps ready_o=1); outputs sampled 1ns later.
  task automatic xfer(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic clr);
    valid_i = 1'b1; ready_i = 1'b1; err_clr_i = clr;
    res1_i = a; res2_i = b; res3_i = c;
    @(posedge clk); #1;
    valid_i = 1'b0; err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; err_clr_i = 1'b0;
    res1_i = '0; res2_i = '0; res3_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
    checks++; if (mismatch_o !== 3'b000) begin errors++; $display("FAIL reset_mm: got %b want 000", mismatch_o); end
    checks++; if ({fault_o, uncorrectable_o, err_cnt_o} !== 12'h0) begin errors++;
      $display("FAIL reset_diag: fault=%b unc=%b cnt=%0d want all 0", fault_o, uncorrectable_o, err_cnt_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_clean_vote();
    xfer(32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 1'b0);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b want 1", valid_o); end
    checks++; if (result_o !== 32'h0000_1234) begin errors++; $display("FAIL clean_result: got %h want 00001234", result_o); end
    checks++; if (mismatch_o !== 3'b000) begin errors++; $display("FAIL clean_mm: got %b want 000", mismatch_o); end
    checks++; if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL clean_cnt: got %0d want 0", err_cnt_o); end
  endtask

  task automatic test_fault_r1();
    for (int i = 1; i <= 3; i++) begin
      xfer(32'hFFFF_FFFF, 32'h0000_00FF, 32'h0000_00FF, 1'b0);
      checks++; if (result_o !== 32'h0000_00FF) begin errors++; $display("FAIL r1_result[%0d]: got %h want 000000ff", i, result_o); end
      checks++; if (mismatch_o !== 3'b001) begin errors++; $display("FAIL r1_mm[%0d]: got %b want 001", i, mismatch_o); end
      checks++; if (err_cnt_o !== 8'(i)) begin errors++; $display("FAIL r1_cnt[%0d]: got %0d want %0d", i, err_cnt_o, i); end
      checks++; if (fault_o !== ((i == 3) ? 3'b001 : 3'b000)) begin errors++;
        $display("FAIL r1_fault[%0d]: got %b want %b", i, fault_o, (i == 3) ? 3'b001 : 3'b000); end
    end
  endtask

  task automatic test_streak_break_r2();
    // standalone clear: no accept in this cycle
    err_clr_i = 1'b1; @(posedge clk); #1; err_clr_i = 1'b0;
    checks++; if ({fault_o, err_cnt_o} !== 11'h0) begin errors++;
      $display("FAIL clr_only: fault=%b cnt=%0d want 000/0", fault_o, err_cnt_o); end
    xfer(32'hA, 32'hB, 32'hA, 1'b0);
    xfer(32'hA, 32'hB, 32'hA, 1'b0);
    xfer(32'hA, 32'hA, 32'hA, 1'b0);
    checks++; if (mismatch_o !== 3'b000) begin errors++; $display("FAIL r2_match_mm: got %b want 000", mismatch_o); end
    xfer(32'hA, 32'hB, 32'hA, 1'b0);
    xfer(32'hA, 32'hB, 32'hA, 1'b0);
    checks++; if (mismatch_o !== 3'b010) begin errors++; $display("FAIL r2_mm: got %b want 010", mismatch_o); end
    checks++; if (fault_o !== 3'b000) begin errors++; $display("FAIL r2_fault: got %b want 000", fault_o); end
    checks++; if (err_cnt_o !== 8'd4) begin errors++; $display("FAIL r2_cnt: got %0d want 4", err_cnt_o); end
    checks++; if (err_cnt_o2 !== 2'd3) begin errors++; $display("FAIL r2_cnt_w2: got %0d want 3", err_cnt_o2); end
  endtask

  task automatic test_triple_and_clear();
    xfer(32'h1, 32'h2, 32'h4, 1'b0);
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL tri_result: got %h want 0", result_o); end
    checks++; if (mismatch_o !== 3'b111) begin errors++; $display("FAIL tri_mm: got %b want 111", mismatch_o); end
    checks++; if (uncorrectable_o !== 1'b1) begin errors++; $display("FAIL tri_unc: got %b want 1", uncorrectable_o); end
    // replica 2 had a 2-long streak left over, so this third mismatch condemns it
    checks++; if (fault_o !== 3'b010) begin errors++; $display("FAIL tri_fault: got %b want 010", fault_o); end
    checks++; if (err_cnt_o !== 8'd5) begin errors++; $display("FAIL tri_cnt: got %0d want 5", err_cnt_o); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (uncorrectable_o !== 1'b1) begin errors++; $display("FAIL tri_sticky: got %b want 1", uncorrectable_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL tri_drain: got %b want 0", valid_o); end
    xfer(32'h5, 32'h7, 32'h7, 1'b1);
    checks++; if ({uncorrectable_o, fault_o, err_cnt_o} !== 12'h0) begin errors++;
      $display("FAIL clr_diag: unc=%b fault=%b cnt=%0d want 0/000/0", uncorrectable_o, fault_o, err_cnt_o); end
    checks++; if (valid_o !== 1'b1 || result_o !== 32'h7 || mismatch_o !== 3'b001) begin errors++;
      $display("FAIL clr_data: valid=%b result=%h mm=%b want 1/7/001", valid_o, result_o, mismatch_o); end
  endtask

  task automatic test_backpressure();
    xfer(32'h55, 32'h55, 32'h55, 1'b0);
    ready_i = 1'b0; valid_i = 1'b1;
    res1_i = 32'h11; res2_i = 32'h33; res3_i = 32'h33;
    #1;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", ready_o); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b1 || result_o !== 32'h55 || mismatch_o !== 3'b000) begin errors++;
      $display("FAIL bp_hold: valid=%b result=%h mm=%b want 1/55/000", valid_o, result_o, mismatch_o); end
    checks++; if ({fault_o, err_cnt_o} !== 11'h0) begin errors++;
      $display("FAIL bp_diag: fault=%b cnt=%0d want 000/0", fault_o, err_cnt_o); end
    ready_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", ready_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || result_o !== 32'h33 || mismatch_o !== 3'b001) begin errors++;
      $display("FAIL b2b_data: valid=%b result=%h mm=%b want 1/33/001", valid_o, result_o, mismatch_o); end
    checks++; if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL b2b_cnt: got %0d want 1", err_cnt_o); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL handoff_empty: got %b want 0", valid_o); end
  endtask

  task automatic test_saturation_and_reset();
    err_clr_i = 1'b1; @(posedge clk); #1; err_clr_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      xfer(32'h0, 32'hF0, 32'hF0, 1'b0);
      checks++; if (err_cnt_o2 !== ((i < 3) ? 2'(i) : 2'd3)) begin errors++;
        $display("FAIL sat_w2[%0d]: got %0d want %0d", i, err_cnt_o2, (i < 3) ? i : 3); end
      checks++; if (err_cnt_o !== 8'(i)) begin errors++; $display("FAIL sat_w8[%0d]: got %0d want %0d", i, err_cnt_o, i); end
    end
    checks++; if (fault_o !== 3'b001) begin errors++; $display("FAIL sat_fault: got %b want 001", fault_o); end
    ready_i = 1'b0; rst_n = 1'b0; valid_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    checks++; if (valid_o !== 1'b0 || valid_o2 !== 1'b0) begin errors++;
      $display("FAIL midrst_valid: got %b/%b want 0/0", valid_o, valid_o2); end
    checks++; if ({fault_o, uncorrectable_o, err_cnt_o, err_cnt_o2} !== 14'h0) begin errors++;
      $display("FAIL midrst_diag: fault=%b unc=%b cnt=%0d cnt2=%0d want 0", fault_o, uncorrectable_o, err_cnt_o, err_cnt_o2); end
  endtask

  initial begin
    test_reset();
    test_clean_vote();
    test_fault_r1();
    test_streak_break_r2();
    test_triple_and_clear();
    test_backpressure();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_fault_monitor.md
Name: cv32e40p_tmr_fault_monitor

Overview:
- Sits directly downstream of the three replicated cv32e40p_alu instances in the TMR EX stage.
- Consumes the raw replica results, registers the bitwise-majority result into a one-entry valid/ready output stage, and diagnoses the replicas.
- Diagnosis covers per-replica mismatch detection, a consecutive-mismatch state machine that condemns a replica as faulty, a saturating mismatch-event counter, and a sticky uncorrectable flag.

Parameters:
- WIDTH, 32: data width of each replica result.
- THRESH, 3: consecutive mismatching transfers that mark a replica faulty. Legal range 1..15.
- CNT_W, 8: width of the saturating mismatch-event counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- valid_i  input  1  replica results are valid.
- ready_o  output  1  block can accept a transfer.
- res1_i  input  WIDTH  replica 1 result.
- res2_i  input  WIDTH  replica 2 result.
- res3_i  input  WIDTH  replica 3 result.
- valid_o  output  1  result_o holds valid data.
- ready_i  input  1  downstream consumes result_o.
- result_o  output  WIDTH  registered bitwise-majority result.
- mismatch_o  output  3  registered per-replica mismatch flags for the transfer held in result_o.
- err_clr_i  input  1  clears diagnosis state.
- fault_o  output  3  replica k is in FAULTY state.
- uncorrectable_o  output  1  sticky: a transfer had all three replicas pairwise different.
- err_cnt_o  output  CNT_W  saturating count of accepted transfers with any mismatch.

Behaviour:
- Reset is synchronous on rising clk with rst_n=0, and has priority over every other input. Reset values:
  - valid_o=0, result_o=0, mismatch_o=0.
  - fault_o=0, uncorrectable_o=0, err_cnt_o=0.
  - All replica FSMs HEALTHY, all streak counters 0.
- Reset mid-operation discards a held result without handing it off.
- Handshake:
  - ready_o = !valid_o || ready_i (combinational).
  - Accept = valid_i && ready_o. Handoff = valid_o && ready_i.
  - On accept, the next cycle has result_o = maj, mismatch_o = mm, valid_o=1. Latency is 1 cycle.
  - Simultaneous handoff and accept gives back-to-back throughput of 1 per cycle.
  - Handoff without accept sets valid_o=0.
  - While valid_o=1 and ready_i=0, result_o and mismatch_o are held stable.
- Vote: maj = (r1&r2)|(r2&r3)|(r1&r3), bitwise.
- Mismatch: mm[k] = (res_k != maj).
- Triple disagreement: (r1!=r2)&&(r2!=r3)&&(r1!=r3). maj is still forwarded.
- Diagnosis updates only on accept, and only when err_clr_i=0.
- Per-replica FSM, one per replica, with a 4-bit streak counter:
  - HEALTHY:
    - mm=0: stay.
    - mm=1: streak=1, go to SUSPECT; go directly to FAULTY if THRESH==1.
  - SUSPECT:
    - mm=1: streak+1; go to FAULTY when streak reaches THRESH.
    - mm=0: go to HEALTHY, streak=0.
  - FAULTY: sticky, streak frozen; leaves only via err_clr_i or reset.
- fault_o[k] = (state_k == FAULTY), registered, visible the cycle after the deciding accept.
- err_cnt_o increments by 1 on an accept with |mm. It saturates at 2^CNT_W-1 and never wraps.
- uncorrectable_o is set on an accept with triple disagreement. It is sticky until err_clr_i or reset.
- err_clr_i=1:
  - Next cycle: all FSMs HEALTHY, streaks=0, fault_o=0, err_cnt_o=0, uncorrectable_o=0.
  - Clear has priority over a same-cycle accept: that transfer's diagnosis is discarded, but its data and mismatch_o still pass through normally.
- The datapath (valid_o, result_o, mismatch_o) is unaffected by err_clr_i.
- Non-accept cycles never change diagnosis state, including cycles where valid_i=1 with ready_o=0.

Test Plan:
- Reset, then accept r1=r2=r3=0x0000_1234 with ready_i=1 -> next cycle valid_o=1, result_o=0x0000_1234, mismatch_o=000, err_cnt_o=0.
- r1=0xFFFF_FFFF, r2=r3=0x0000_00FF for 3 consecutive accepts (THRESH=3) -> result_o=0x0000_00FF each time, mismatch_o=001, err_cnt_o 1,2,3, fault_o=001 after the 3rd accept.
- Replica 2 mismatches on 2 accepts, then matches on the 3rd, then mismatches on 2 more -> fault_o stays 000; err_cnt_o=4.
- r1=0x1, r2=0x2, r3=0x4 -> result_o=0x0, mismatch_o=111, uncorrectable_o=1 and stays 1. Then pulse err_clr_i together with an accept of a replica-1 mismatch -> uncorrectable_o=0, err_cnt_o=0, fault_o=000, that transfer's mismatch_o=001 still delivered.
- Backpressure: hold ready_i=0 with valid_o=1 and present new valid_i with mismatches -> ready_o=0, result_o held, no counter or FSM change. Raise ready_i -> handoff and accept in the same cycle, new result next cycle.
- CNT_W=2: 5 mismatching accepts -> err_cnt_o reads 1,2,3,3,3. Assert rst_n=0 while valid_o=1 -> next cycle valid_o=0 and all diagnosis outputs 0.
